// File: rtl/atb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package    : atb_pkg                                                 |
// | Description: Shared types and sizes for the address target buffer   |
// |              and its update/maintenance controller.                  |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
package atb_pkg;

    // Default ATB geometry; the ATB itself sizes its index from this.
    localparam int ATB_N     = 256;
    localparam int ATB_IDX_W = $clog2(ATB_N);

    // One pending target update: branch PC and its resolved target.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] tgt_pc;
    } atb_upd_t;

    // Controller modes: normal update traffic, or full-table invalidation walk.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } atb_ctrl_state_e;

endpackage
`default_nettype wire

// File: rtl/atb_upd_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : atb_upd_fifo                                            |
// | Description: Two-in / one-out circular queue of ATB updates with a  |
// |              synchronous clear. Slot 0 is stored ahead of slot 1.    |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module atb_upd_fifo
    import atb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       clear,
    input  logic                       push0,
    input  atb_upd_t                   data0,
    input  logic                       push1,
    input  atb_upd_t                   data1,
    input  logic                       pop,
    output atb_upd_t                   head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    atb_upd_t           mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr_slot1;

    // Slot 1 lands just behind slot 0 when both are written together.
    assign wr_ptr_slot1 = wr_ptr + PTR_W'(push0);
    assign head         = mem[rd_ptr];

    // Storage array; a clear discards the whole cycle's writes.
    always_ff @(posedge clk) begin
        if (!clear) begin
            if (push0) mem[wr_ptr]       <= data0;
            if (push1) mem[wr_ptr_slot1] <= data1;
        end
    end

    // Pointers wrap modulo DEPTH; count tracks occupancy directly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(push0) + PTR_W'(push1);
            rd_ptr <= rd_ptr + PTR_W'(pop);
            count  <= count + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/atb_update_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : atb_update_ctrl                                         |
// | Description: Queues retire-time ATB target updates from two retire  |
// |              slots, writes them one per cycle, and runs a full-table |
// |              invalidation walk on request.                           |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module atb_update_ctrl
    import atb_pkg::*;
#(
    parameter int N     = 256,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 retire0_valid_i,
    input  logic [31:0]          retire0_pc_i,
    input  logic [31:0]          retire0_tgt_pc_i,
    input  logic                 retire1_valid_i,
    input  logic [31:0]          retire1_pc_i,
    input  logic [31:0]          retire1_tgt_pc_i,
    output logic                 retire_ready_o,
    input  logic                 flush_req_i,
    output logic                 flush_busy_o,
    output logic                 atb_wr_valid_o,
    output logic [31:0]          atb_wr_pc_o,
    output logic [31:0]          atb_wr_tgt_pc_o,
    output logic                 atb_inv_valid_o,
    output logic [$clog2(N)-1:0] atb_inv_idx_o
);

    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(DEPTH + 1);

    atb_ctrl_state_e    state;
    atb_ctrl_state_e    next_state;
    logic [IDX_W-1:0]   flush_cnt;
    logic [CNT_W-1:0]   q_count;
    atb_upd_t           q_head;
    logic               start_flush;
    logic               do_pop;
    logic               push0;
    logic               push1;

    // Ready needs room for two entries, judged on the registered count.
    assign retire_ready_o = (state == IDLE) && (q_count <= CNT_W'(DEPTH - 2));
    assign flush_busy_o   = (state == FLUSH) || atb_inv_valid_o;

    // Mode register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // Next mode plus per-cycle queue controls; a flush request beats a pop.
    always_comb begin
        next_state  = state;
        start_flush = 1'b0;
        do_pop      = 1'b0;
        push0       = 1'b0;
        push1       = 1'b0;
        case (state)
            IDLE: begin
                if (flush_req_i) begin
                    next_state  = FLUSH;
                    start_flush = 1'b1;
                end else begin
                    do_pop = (q_count != '0);
                    if (retire_ready_o) begin
                        // Same PC in both slots: the younger target supersedes.
                        push0 = retire0_valid_i &&
                                !(retire1_valid_i && (retire0_pc_i == retire1_pc_i));
                        push1 = retire1_valid_i;
                    end
                end
            end
            FLUSH: begin
                if (flush_cnt == IDX_W'(N - 1)) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Walk index: restarts at 0 when a walk begins, steps once per walk cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)            flush_cnt <= '0;
        else if (start_flush)    flush_cnt <= '0;
        else if (state == FLUSH) flush_cnt <= flush_cnt + IDX_W'(1);
    end

    // Registered ATB-facing write and invalidate ports.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            atb_wr_valid_o  <= 1'b0;
            atb_wr_pc_o     <= '0;
            atb_wr_tgt_pc_o <= '0;
            atb_inv_valid_o <= 1'b0;
            atb_inv_idx_o   <= '0;
        end else begin
            atb_wr_valid_o  <= do_pop;
            atb_inv_valid_o <= (state == FLUSH);
            if (do_pop) begin
                atb_wr_pc_o     <= q_head.pc;
                atb_wr_tgt_pc_o <= q_head.tgt_pc;
            end
            if (state == FLUSH) atb_inv_idx_o <= flush_cnt;
        end
    end

    atb_upd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (start_flush),
        .push0   (push0),
        .data0   ('{pc: retire0_pc_i, tgt_pc: retire0_tgt_pc_i}),
        .push1   (push1),
        .data1   ('{pc: retire1_pc_i, tgt_pc: retire1_tgt_pc_i}),
        .pop     (do_pop),
        .head    (q_head),
        .count   (q_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_atb_update_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : tb_atb_update_ctrl                                      |
// | Description: Self-checking bench for atb_update_ctrl: vector table,  |
// |              directed corner sequences and randomized traffic        |
// |              against a queue-based reference model.                  |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module tb_atb_update_ctrl;

    localparam int N     = 256;
    localparam int DEPTH = 4;

    logic        clk;
    logic        reset_n;
    logic        retire0_valid_i, retire1_valid_i;
    logic [31:0] retire0_pc_i, retire0_tgt_pc_i, retire1_pc_i, retire1_tgt_pc_i;
    logic        retire_ready_o;
    logic        flush_req_i;
    logic        flush_busy_o;
    logic        atb_wr_valid_o;
    logic [31:0] atb_wr_pc_o, atb_wr_tgt_pc_o;
    logic        atb_inv_valid_o;
    logic [7:0]  atb_inv_idx_o;

    atb_update_ctrl #(.N(N), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .retire0_valid_i  (retire0_valid_i),
        .retire0_pc_i     (retire0_pc_i),
        .retire0_tgt_pc_i (retire0_tgt_pc_i),
        .retire1_valid_i  (retire1_valid_i),
        .retire1_pc_i     (retire1_pc_i),
        .retire1_tgt_pc_i (retire1_tgt_pc_i),
        .retire_ready_o   (retire_ready_o),
        .flush_req_i      (flush_req_i),
        .flush_busy_o     (flush_busy_o),
        .atb_wr_valid_o   (atb_wr_valid_o),
        .atb_wr_pc_o      (atb_wr_pc_o),
        .atb_wr_tgt_pc_o  (atb_wr_tgt_pc_o),
        .atb_inv_valid_o  (atb_inv_valid_o),
        .atb_inv_idx_o    (atb_inv_idx_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: pending updates as a plain queue, walk as a countdown.
    typedef struct { logic [31:0] pc; logic [31:0] tgt; } upd_t;
    upd_t        mq[$];
    int          m_walk;
    logic        e_wr_valid;
    logic [31:0] e_wr_pc, e_wr_tgt;
    logic        e_inv_valid;
    int          e_inv_idx;
    bit          last_rdy;
    int          wr_seen;

    typedef struct {
        logic v0; logic [31:0] pc0; logic [31:0] t0;
        logic v1; logic [31:0] pc1; logic [31:0] t1;
        logic exp_rdy; logic exp_wr; logic [31:0] exp_pc; logic [31:0] exp_tgt;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic v0, input logic [31:0] pc0, input logic [31:0] t0,
                          input logic v1, input logic [31:0] pc1, input logic [31:0] t1,
                          input logic fl);
        retire0_valid_i = v0; retire0_pc_i = pc0; retire0_tgt_pc_i = t0;
        retire1_valid_i = v1; retire1_pc_i = pc1; retire1_tgt_pc_i = t1;
        flush_req_i = fl;
    endtask

    task automatic set_idle();
        set_in(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic model_reset();
        mq.delete();
        m_walk = 0; e_wr_valid = 0; e_wr_pc = 0; e_wr_tgt = 0;
        e_inv_valid = 0; e_inv_idx = 0;
    endtask

    // One clock: check ready, advance the model on the edge, check outputs.
    task automatic step();
        bit fl, rdy;
        logic v0, v1, frq;
        logic [31:0] pc0, t0, pc1, t1;
        upd_t u;
        v0 = retire0_valid_i; pc0 = retire0_pc_i; t0 = retire0_tgt_pc_i;
        v1 = retire1_valid_i; pc1 = retire1_pc_i; t1 = retire1_tgt_pc_i;
        frq = flush_req_i;
        fl  = (m_walk > 0);
        rdy = !fl && ((DEPTH - mq.size()) >= 2);
        last_rdy = rdy;
        chk("retire_ready", retire_ready_o, rdy);
        @(posedge clk);
        e_wr_valid  = 0;
        e_inv_valid = 0;
        if (fl) begin
            e_inv_valid = 1;
            e_inv_idx   = N - m_walk;
            m_walk--;
        end else if (frq) begin
            mq.delete();
            m_walk = N;
        end else begin
            if (mq.size() > 0) begin
                u = mq.pop_front();
                e_wr_valid = 1; e_wr_pc = u.pc; e_wr_tgt = u.tgt;
            end
            if (rdy) begin
                if (v0 && !(v1 && pc0 == pc1)) mq.push_back('{pc: pc0, tgt: t0});
                if (v1) mq.push_back('{pc: pc1, tgt: t1});
            end
        end
        #1;
        chk("wr_valid", atb_wr_valid_o, e_wr_valid);
        if (e_wr_valid) begin
            chk("wr_pc", atb_wr_pc_o, e_wr_pc);
            chk("wr_tgt", atb_wr_tgt_pc_o, e_wr_tgt);
        end
        chk("inv_valid", atb_inv_valid_o, e_inv_valid);
        if (e_inv_valid) chk("inv_idx", atb_inv_idx_o, e_inv_idx);
        chk("flush_busy", flush_busy_o, (m_walk > 0) || e_inv_valid);
        if (atb_wr_valid_o) wr_seen++;
    endtask

    initial begin
        int  acc, inv_cnt, wr_during;
        bit  saw_low, found;

        clk = 0; reset_n = 0; wr_seen = 0;
        set_idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", retire_ready_o, 1);
        chk("rst_busy", flush_busy_o, 0);
        chk("rst_wr_valid", atb_wr_valid_o, 0);
        chk("rst_wr_pc", atb_wr_pc_o, 0);
        chk("rst_wr_tgt", atb_wr_tgt_pc_o, 0);
        chk("rst_inv_valid", atb_inv_valid_o, 0);
        chk("rst_inv_idx", atb_inv_idx_o, 0);
        reset_n = 1;

        // Vector table: single update, dual distinct, coalescing.
        tbl[0] = '{1, 32'h10, 32'h1000, 0, 0, 0,                1, 0, 0, 0};
        tbl[1] = '{0, 0, 0, 0, 0, 0,                            1, 1, 32'h10, 32'h1000};
        tbl[2] = '{1, 32'h20, 32'h2000, 1, 32'h24, 32'h2400,    1, 0, 0, 0};
        tbl[3] = '{0, 0, 0, 0, 0, 0,                            1, 1, 32'h20, 32'h2000};
        tbl[4] = '{0, 0, 0, 0, 0, 0,                            1, 1, 32'h24, 32'h2400};
        tbl[5] = '{1, 32'h30, 32'h3000, 1, 32'h30, 32'h3100,    1, 0, 0, 0};
        tbl[6] = '{0, 0, 0, 0, 0, 0,                            1, 1, 32'h30, 32'h3100};
        tbl[7] = '{0, 0, 0, 0, 0, 0,                            1, 0, 0, 0};
        for (int i = 0; i < 8; i++) begin
            set_in(tbl[i].v0, tbl[i].pc0, tbl[i].t0, tbl[i].v1, tbl[i].pc1, tbl[i].t1, 0);
            chk($sformatf("vec%0d_ready", i), retire_ready_o, tbl[i].exp_rdy);
            step();
            chk($sformatf("vec%0d_wr_valid", i), atb_wr_valid_o, tbl[i].exp_wr);
            if (tbl[i].exp_wr) begin
                chk($sformatf("vec%0d_wr_pc", i), atb_wr_pc_o, tbl[i].exp_pc);
                chk($sformatf("vec%0d_wr_tgt", i), atb_wr_tgt_pc_o, tbl[i].exp_tgt);
            end
        end

        // Queue full: eight back-to-back dual retires, then drain.
        acc = 0; saw_low = 0; wr_seen = 0;
        for (int c = 0; c < 8; c++) begin
            set_in(1, 32'h100 + 8 * c, 32'h1100 + 8 * c, 1, 32'h104 + 8 * c, 32'h1104 + 8 * c, 0);
            step();
            if (last_rdy) acc += 2;
            else          saw_low = 1;
        end
        set_idle();
        repeat (8) step();
        chk("qfull_ready_dropped", saw_low, 1);
        chk("qfull_no_loss", wr_seen, acc);

        // Flush with three pending updates; a second request mid-walk is ignored.
        set_in(1, 32'h200, 32'h2200, 1, 32'h204, 32'h2204, 0); step();
        set_in(1, 32'h208, 32'h2208, 1, 32'h20c, 32'h220c, 0); step();
        set_in(1, 32'h210, 32'h2210, 1, 32'h214, 32'h2214, 1); step();
        chk("flush_busy_rise", flush_busy_o, 1);
        inv_cnt = 0; wr_during = 0;
        for (int c = 0; c < 300; c++) begin
            if (c == 50) set_in(0, 0, 0, 0, 0, 0, 1);
            else         set_idle();
            step();
            if (atb_inv_valid_o) begin
                chk("flush_idx_seq", atb_inv_idx_o, inv_cnt);
                inv_cnt++;
            end
            if (atb_wr_valid_o) wr_during++;
        end
        chk("flush_inv_count", inv_cnt, N);
        chk("flush_no_write", wr_during, 0);
        chk("flush_ready_after", retire_ready_o, 1);

        // Reset in the middle of a walk.
        set_in(0, 0, 0, 0, 0, 0, 1); step();
        set_idle();
        found = 0;
        for (int c = 0; c < 300 && !found; c++) begin
            step();
            if (atb_inv_valid_o && atb_inv_idx_o == 8'd100) found = 1;
        end
        chk("reached_idx100", found, 1);
        #1 reset_n = 0;
        #1;
        chk("midrst_busy", flush_busy_o, 0);
        chk("midrst_inv_valid", atb_inv_valid_o, 0);
        chk("midrst_inv_idx", atb_inv_idx_o, 0);
        chk("midrst_wr_valid", atb_wr_valid_o, 0);
        chk("midrst_ready", retire_ready_o, 1);
        model_reset();
        @(negedge clk);
        reset_n = 1;
        set_in(1, 32'h500, 32'h5000, 0, 0, 0, 0); step();
        set_idle(); step();
        chk("postrst_wr_valid", atb_wr_valid_o, 1);
        chk("postrst_wr_pc", atb_wr_pc_o, 32'h500);
        chk("postrst_wr_tgt", atb_wr_tgt_pc_o, 32'h5000);

        // Randomized traffic with a small PC pool so coalescing happens often.
        for (int c = 0; c < 600; c++) begin
            set_in(1'($urandom_range(0, 1)), 32'h40 + 4 * $urandom_range(0, 3), $urandom,
                   1'($urandom_range(0, 1)), 32'h40 + 4 * $urandom_range(0, 3), $urandom,
                   1'($urandom_range(0, 99) == 0));
            step();
        end
        set_idle();
        repeat (300) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/atb_update_ctrl.md
# atb_update_ctrl

Update and maintenance controller for the address target buffer. It collects retire-time target updates from two retire slots, queues them, and serialises them onto the ATB's single write port at one per cycle. It also sequences a full-table invalidation walk on request, and holds off retire traffic while the walk runs. It sits between the retire stage and the ATB write/invalidate ports, in the same clock domain as the ATB.

## Interface
- N, 256: number of ATB entries (power of two); sets the flush walk length and the index width.
- DEPTH, 4: update queue depth in entries (power of two, ≥2).
- clk  in  1  core clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- retire0_valid_i  in  1  retire slot 0 (older) carries a resolved branch target.
- retire0_pc_i  in  32  slot 0 branch PC.
- retire0_tgt_pc_i  in  32  slot 0 branch target.
- retire1_valid_i  in  1  retire slot 1 (younger) carries a resolved branch target.
- retire1_pc_i  in  32  slot 1 branch PC.
- retire1_tgt_pc_i  in  32  slot 1 branch target.
- retire_ready_o  out  1  the controller accepts both retire slots this cycle.
- flush_req_i  in  1  single-cycle request to invalidate the whole ATB.
- flush_busy_o  out  1  invalidation walk in progress; ATB lookups must be treated as misses.
- atb_wr_valid_o  out  1  write one entry to the ATB this cycle.
- atb_wr_pc_o  out  32  PC for the ATB write.
- atb_wr_tgt_pc_o  out  32  target for the ATB write.
- atb_inv_valid_o  out  1  invalidate one ATB entry this cycle.
- atb_inv_idx_o  out  $clog2(N)  index of the entry to invalidate.

## Operation
- FSM states: IDLE and FLUSH. Reset state: IDLE.
- **IDLE → FLUSH:** on flush_req_i. The index counter loads 0 and all queued updates are discarded, so count becomes 0.
- **FLUSH:** one invalidate per cycle with atb_inv_idx_o = counter; the counter increments each cycle.
- **FLUSH → IDLE:** after the cycle in which index N-1 is issued. The walk takes exactly N cycles.
- flush_req_i while in FLUSH is ignored; the walk is not restarted.
- **Enqueue:** only in IDLE with retire_ready_o=1. Slot 0 is written before slot 1, and valid-low slots are skipped.
- **Same-PC coalescing:** if both slots are valid and retire0_pc_i == retire1_pc_i, only slot 1 is enqueued (the younger target wins).
- retire_ready_o = (state==IDLE) && (DEPTH − count ≥ 2). This is based on the registered count, so a dequeue in the same cycle does not create space.
- Retire slots presented with retire_ready_o=0 are dropped; the retire stage owns any retry.
- **Dequeue:** in IDLE, when count>0 and flush_req_i is low, pop the head onto the write outputs (at most one per cycle).
- Enqueue and dequeue may occur in the same cycle; count updates by (enqueued − dequeued).
- The queue is a circular buffer. Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count is $clog2(DEPTH+1) bits.
- Write outputs and invalidate outputs are never asserted together. A flush takes priority over a pending dequeue.

## Timing
- Reset values:
  - retire_ready_o=1
  - flush_busy_o=0
  - atb_wr_valid_o=0, atb_wr_pc_o=0, atb_wr_tgt_pc_o=0
  - atb_inv_valid_o=0, atb_inv_idx_o=0
- All ATB-facing outputs are registered.
- **Update latency:** a slot accepted at edge t into an empty queue drives atb_wr_valid_o during the cycle after edge t+1. An update is therefore visible in the ATB two edges after its retire edge.
- **Flush timing:**
  - flush_req_i sampled at edge t sets flush_busy_o from edge t.
  - atb_inv_valid_o is asserted from edge t+1 for N cycles, with indices 0..N-1.
  - flush_busy_o falls at the same edge as atb_inv_valid_o.
- flush_busy_o = (state==FLUSH) || atb_inv_valid_o.
- **Backpressure:** retire_ready_o is low for the whole walk and rises on the edge that returns the FSM to IDLE.
- **Throughput:** a steady stream of two updates per cycle fills the queue, after which retire_ready_o alternates as the queue drains at one per cycle.
- **Reset mid-operation:** asynchronous reset returns the FSM to IDLE, empties the queue, and clears all outputs immediately. No partial walk resumes.

## Structure
- Shared package atb_pkg holds:
  - the typedef atb_upd_t {pc[31:0], tgt_pc[31:0]};
  - the enum atb_ctrl_state_e {IDLE, FLUSH};
  - the localparam ATB_IDX_W = $clog2(N).
- The package is shared with the ATB itself.
- One sub-module: atb_upd_fifo. It is a 2-in/1-out circular queue of atb_upd_t with push0/push1/pop, count output and a synchronous clear.
- The FSM and flush counter live in the top module.

## Test plan
- Single update: after reset, retire0 (pc 0x10, tgt 0x1000) → one cycle of atb_wr_valid_o with 0x10/0x1000, two edges after retire.
- Dual retire, distinct PCs: slot0 0x20/0x2000 and slot1 0x24/0x2400 in the same cycle → writes on consecutive cycles, 0x20 first then 0x24.
- Coalescing: both slots use pc 0x30, with tgt 0x3000 (slot 0) and 0x3100 (slot 1) → a single write of 0x30/0x3100.
- Queue full: eight consecutive cycles of dual retires with DEPTH=4 → retire_ready_o drops once count ≥3. No more than four entries are ever held, and no write is lost among accepted slots.
- Flush with pending updates: three entries queued, then flush_req_i → queue is discarded and flush_busy_o rises. With N=256, atb_inv_idx_o runs 0..255 over 256 cycles, no atb_wr_valid_o occurs, and retire_ready_o rises afterward.
- Reset mid-flush: assert reset_n=0 at index 100 → all outputs are 0 immediately. After release the state is IDLE with retire_ready_o=1, and a new retire is written normally.
